// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - loader state encoding and IMEM depth helper
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4,
    ST_ERROR   = 3'd5
  } loader_state_e;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - program word stream in, IMEM write port out
interface program_loader_if #(
  parameter int ADDR_W = 10
);
  logic              s_valid;
  logic              s_ready;
  logic [31:0]       s_data;
  logic              s_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/loader_release_timer.sv
// rtl/loader_release_timer.sv - load/count-down timer holding the core in reset
module loader_release_timer #(
  parameter int CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic done
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] START = CW'(CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // Loading CYCLES-1 makes done visible on the CYCLES-th enabled cycle.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = START;
    end else if (enable && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);
endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a program image into IMEM, then releases the core
// Optional trailing XOR checksum word: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  program_loader_if.slave   bus,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   word_count
);
  localparam int unsigned DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              timer_load;
  logic              timer_done;
  logic              xfer;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif

  assign bus.s_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign xfer        = bus.s_valid && bus.s_ready;

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    timer_load   = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (load_start) begin
          state_d      = ST_LOAD;
          word_count_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d       = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          // A full image leaves no room: any further word is an overrun.
          if (word_count_q == DEPTH_CNT) begin
            state_d = ST_ERROR;
          end else begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_count_q[ADDR_W-1:0];
            imem_wdata_d = bus.s_data;
            word_count_d = word_count_q + 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_d       = csum_q ^ bus.s_data;
            if (bus.s_last) begin
              state_d = ST_CHECK;
            end
`else
            if (bus.s_last) begin
              state_d    = ST_RELEASE;
              timer_load = 1'b1;
            end
`endif
          end
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer) begin
          if (bus.s_data == csum_q) begin
            state_d    = ST_RELEASE;
            timer_load = 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
`endif
      ST_RELEASE: begin
        if (timer_done) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      word_count_q <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  loader_release_timer #(
    .CYCLES (RELEASE_CYCLES)
  ) u_release_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (timer_load),
    .enable (state_q == ST_RELEASE),
    .done   (timer_done)
  );

  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign core_reset     = (state_q != ST_RUN);
  assign load_done      = (state_q == ST_RUN);
  assign load_error     = (state_q == ST_ERROR);
  assign word_count     = word_count_q;
endmodule
